// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 Hz VGA: pixel/line counters, syncs, blanking,
// line/frame strobes and a free-running frame counter, one pixel per clk.
module vga_timing_gen #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic [7:0] fc_next;
  logic       hs_next;
  logic       vs_next;
  logic       de_next;

  // Sync and blanking are decoded from the next counter values so that, once
  // registered, they line up with pix_x/pix_y on the same cycle.
  always_comb begin
    h_wrap  = (pix_x == 10'(H_TOTAL - 1));
    v_wrap  = (pix_y == 10'(V_TOTAL - 1));
    x_next  = h_wrap ? 10'd0 : pix_x + 10'd1;
    y_next  = pix_y;
    fc_next = frame_cnt;
    if (h_wrap) begin
      y_next = v_wrap ? 10'd0 : pix_y + 10'd1;
      if (v_wrap) begin
        fc_next = frame_cnt + 8'd1;
      end
    end
    hs_next = (x_next >= 10'(HS_START)) && (x_next < 10'(HS_END));
    vs_next = (y_next >= 10'(VS_START)) && (y_next < 10'(VS_END));
    de_next = (x_next < 10'(H_DISPLAY)) && (y_next < 10'(V_DISPLAY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      frame_cnt  <= 8'd0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      display_on <= 1'b1;
    end else begin
      pix_x      <= x_next;
      pix_y      <= y_next;
      frame_cnt  <= fc_next;
      hsync      <= hs_next ? SYNC_POL : ~SYNC_POL;
      vsync      <= vs_next ? SYNC_POL : ~SYNC_POL;
      display_on <= de_next;
    end
  end

  assign line_start  = (pix_x == 10'd0);
  assign frame_start = line_start && (pix_y == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for horizontal corner points and a
// shrunken-timing instance so whole frames and the frame counter wrap fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       de;
    logic       ls;
    logic       fs;
  } vec_t;

  // small timing: H 8+2+3+2 = 15, V 6+2+2+1 = 11, frame = 165 clocks
  localparam int SH_D = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_D = 6, SV_F = 2, SV_S = 2, SV_B = 1;
  localparam int S_FRAME = 165;

  logic       clk;
  logic       rst_a, rst_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [7:0] fc_a, fc_b;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    t_a = 0, t_b = 0;
  bit    armed_a = 0, armed_b = 0;
  vec_t  vecs[$];

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_x(x_a), .pix_y(y_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_x(x_b), .pix_y(y_b), .hsync(hs_b), .vsync(vs_b),
    .display_on(de_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: everything follows from clocks elapsed since reset, by plain division.
  function automatic obs_t model(input int t, input int hd, hf, hs, hb, vd, vf, vs, vb);
    obs_t o;
    int ht, vt, x, line, y;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    x    = t % ht;
    line = t / ht;
    y    = line % vt;
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.hs = ((x >= hd + hf) && (x < hd + hf + hs)) ? 1'b0 : 1'b1;
    o.vs = ((y >= vd + vf) && (y < vd + vf + vs)) ? 1'b0 : 1'b1;
    o.de = (x < hd) && (y < vd);
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    o.fc = 8'((line / vt) % 256);
    return o;
  endfunction

  function automatic obs_t obs_a();
    return '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, de: de_a, ls: ls_a, fs: fs_a, fc: fc_a};
  endfunction

  function automatic obs_t obs_b();
    return '{x: x_b, y: y_b, hs: hs_b, vs: vs_b, de: de_b, ls: ls_b, fs: fs_b, fc: fc_b};
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
               name, act.x, act.y, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_models();
    if (armed_a) check_obs("model_a", obs_a(), model(t_a, 640, 16, 96, 48, 480, 10, 2, 33));
    if (armed_b) check_obs("model_b", obs_b(),
                           model(t_b, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B));
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic ra, rb;
    ra = rst_a;
    rb = rst_b;
    @(posedge clk);
    #1;
    if (ra) begin t_a = 0; armed_a = 1; end else t_a++;
    if (rb) begin t_b = 0; armed_b = 1; end else t_b++;
    check_models();
  endtask

  task automatic check_vec(input vec_t v);
    string nm;
    nm = $sformatf("vec_t%0d", v.t);
    check_obs(nm, obs_a(), '{x: v.x, y: v.y, hs: v.hs, vs: 1'b1, de: v.de, ls: v.ls,
                             fs: v.fs, fc: 8'd0});
  endtask

  int vs_low;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    //            t     x    y   hs  de  ls  fs
    vecs.push_back('{0,    0,   0, 1, 1, 1, 1});
    vecs.push_back('{1,    1,   0, 1, 1, 0, 0});
    vecs.push_back('{639,  639, 0, 1, 1, 0, 0});
    vecs.push_back('{640,  640, 0, 1, 0, 0, 0});
    vecs.push_back('{655,  655, 0, 1, 0, 0, 0});
    vecs.push_back('{656,  656, 0, 0, 0, 0, 0});
    vecs.push_back('{751,  751, 0, 0, 0, 0, 0});
    vecs.push_back('{752,  752, 0, 1, 0, 0, 0});
    vecs.push_back('{799,  799, 0, 1, 0, 0, 0});
    vecs.push_back('{800,  0,   1, 1, 1, 1, 0});
    vecs.push_back('{1439, 639, 1, 1, 1, 0, 0});
    vecs.push_back('{1601, 1,   2, 1, 1, 0, 0});

    // reset held 3 clocks, then walk the corner-point table on the full-size instance
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    foreach (vecs[i]) begin
      while (t_a < vecs[i].t) tick();
      check_vec(vecs[i]);
    end

    // mid-line reset on the full-size instance restarts the sequence exactly
    while (t_a < 2 * 800 + 700) tick();
    rst_a = 1'b1;
    tick();
    check_vec(vecs[0]);
    rst_a = 1'b0;
    tick();
    check_vec(vecs[1]);

    // small instance: reset while both syncs are asserted (x=11, y=9)
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    while (t_b < 9 * 15 + 11) tick();
    check_val("b_hsync_in_pulse", int'(hs_b), 0);
    check_val("b_vsync_in_pulse", int'(vs_b), 0);
    rst_b = 1'b1;
    tick();
    check_obs("b_reset_mid_sync", obs_b(), '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1,
                                              ls: 1'b1, fs: 1'b1, fc: 8'd0});
    rst_b = 1'b0;
    tick();
    check_obs("b_after_release", obs_b(), '{x: 10'd1, y: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1,
                                             ls: 1'b0, fs: 1'b0, fc: 8'd0});

    // one whole frame: vsync low for exactly two lines of 15 clocks
    vs_low = 0;
    while (t_b < S_FRAME) begin
      if (vs_b == 1'b0) vs_low++;
      tick();
    end
    check_val("b_vsync_low_clocks", vs_low, 30);
    check_val("b_frame_cnt_1", int'(fc_b), 1);
    check_val("b_frame_start_1", int'(fs_b), 1);

    // frame counter runs to 255 and wraps on the 256th frame
    while (t_b < 255 * S_FRAME) tick();
    check_val("b_frame_cnt_255", int'(fc_b), 255);
    while (t_b < 256 * S_FRAME) tick();
    check_val("b_frame_cnt_wrap", int'(fc_b), 0);
    check_val("b_frame_start_wrap", int'(fs_b), 1);

    // random run lengths and reset pulses on both instances, checked by the model each clock
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 600)) tick();
      rst_a = 1'($urandom_range(0, 1));
      rst_b = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
    end
    repeat (50) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
